spi_device: RTL and testbench

// SPI device (target) end of the link driven by spi_host: receives bytes on mosi_i,

---
 rtl/spi_device.sv | 210 +++++++++++++++++++++
 tb/tb_spi_device.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_device.sv
// SPI target with oversampled SCK/CSn/MOSI, LSB-first byte shifting, a one-byte TX
// holding register and a valid/ready RX output register. Everything runs on clk_i.
module spi_device #(
   parameter bit CPOL       = 1'b0,
   parameter bit CPHA       = 1'b0,
   parameter int SyncStages = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       sck_i,
   input  logic       csn_i,
   input  logic       mosi_i,
   output logic       miso_o,
   output logic       miso_en_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       busy_o,
   output logic       tx_underrun_o,
   output logic       rx_overrun_o
);

   typedef enum logic [1:0] {StIdle, StLoad, StActive} state_e;

   // Synchroniser reset values per lane: {mosi, csn, sck}; sck rests at its idle level.
   localparam logic [2:0] SyncRst = {1'b0, 1'b1, CPOL};

   logic [2:0] sync_in;
   logic [2:0] sync_out;
   logic       sck_s;
   logic       csn_s;
   logic       mosi_s;

   assign sync_in = {mosi_i, csn_i, sck_i};

   for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic [SyncStages-1:0] chain_reg;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            chain_reg <= {SyncStages{SyncRst[gi]}};
         end else begin
            chain_reg <= {chain_reg[SyncStages-2:0], sync_in[gi]};
         end
      end
      assign sync_out[gi] = chain_reg[SyncStages-1];
   end

   assign sck_s  = sync_out[0];
   assign csn_s  = sync_out[1];
   assign mosi_s = sync_out[2];

   logic   sck_prev_reg;
   logic   csn_prev_reg;
   logic   lead_edge;
   logic   trail_edge;
   logic   sample_edge;
   logic   shift_edge;
   logic   csn_fall;

   state_e state_reg;
   state_e state_next;
   logic   do_load;
   logic   do_sample;
   logic   do_shift;
   logic   byte_done;
   logic   reload;

   logic [7:0] hold_reg;
   logic       hold_full_reg;
   logic       hold_full_next;
   logic       tx_take;
   logic [7:0] reload_byte;
   logic [7:0] tx_shift_reg;
   logic [6:0] rx_shift_reg;
   logic [7:0] rx_byte;
   logic [2:0] cnt_reg;
   logic       miso_reg;
   logic [7:0] rx_data_reg;
   logic       rx_valid_reg;
   logic       tx_underrun_reg;
   logic       rx_overrun_reg;

   assign lead_edge   = (sck_s != CPOL) && (sck_prev_reg == CPOL);
   assign trail_edge  = (sck_s == CPOL) && (sck_prev_reg != CPOL);
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;
   assign csn_fall    = csn_prev_reg && !csn_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sck_prev_reg <= CPOL;
         csn_prev_reg <= 1'b1;
         state_reg    <= StIdle;
      end else begin
         sck_prev_reg <= sck_s;
         csn_prev_reg <= csn_s;
         state_reg    <= state_next;
      end
   end

   // A high synced CSn aborts from any state; serial edges only count while ACTIVE.
   always_comb begin
      state_next = state_reg;
      do_load    = 1'b0;
      do_sample  = 1'b0;
      do_shift   = 1'b0;
      unique case (state_reg)
         StIdle: begin
            if (csn_fall) state_next = StLoad;
         end
         StLoad: begin
            if (csn_s) begin
               state_next = StIdle;
            end else begin
               do_load    = 1'b1;
               state_next = StActive;
            end
         end
         StActive: begin
            if (csn_s) begin
               state_next = StIdle;
            end else begin
               do_sample = sample_edge;
               do_shift  = shift_edge;
            end
         end
         default: state_next = StIdle;
      endcase
   end

   // The shift register is refilled at every byte boundary, so the next byte is
   // committed (and an empty holding register flagged) as soon as a byte completes.
   assign byte_done      = do_sample && (cnt_reg == 3'd7);
   assign reload         = do_load || byte_done;
   assign tx_take        = tx_valid_i && !hold_full_reg;
   assign hold_full_next = tx_take ? 1'b1 : (reload ? 1'b0 : hold_full_reg);
   assign reload_byte    = hold_full_reg ? hold_reg : 8'h00;
   assign rx_byte        = {mosi_s, rx_shift_reg};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_reg        <= 8'h00;
         hold_full_reg   <= 1'b0;
         tx_shift_reg    <= 8'h00;
         tx_underrun_reg <= 1'b0;
      end else begin
         if (tx_take) hold_reg <= tx_data_i;
         hold_full_reg   <= hold_full_next;
         tx_underrun_reg <= reload && !hold_full_reg;
         if (reload) tx_shift_reg <= reload_byte;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         miso_reg     <= 1'b0;
         cnt_reg      <= 3'd0;
         rx_shift_reg <= 7'd0;
      end else if (csn_s) begin
         miso_reg     <= 1'b0;
         cnt_reg      <= 3'd0;
         rx_shift_reg <= 7'd0;
      end else begin
         if (do_load) cnt_reg <= 3'd0;
         if (do_load && !CPHA) begin
            miso_reg <= reload_byte[0];
         end else if (do_shift) begin
            miso_reg <= tx_shift_reg[cnt_reg];
         end
         if (do_sample) begin
            if (cnt_reg != 3'd7) rx_shift_reg[cnt_reg] <= mosi_s;
            cnt_reg <= cnt_reg + 3'd1;
         end
      end
   end

   // A completed byte is dropped only when the previous one is still unaccepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_data_reg    <= 8'h00;
         rx_valid_reg   <= 1'b0;
         rx_overrun_reg <= 1'b0;
      end else begin
         rx_overrun_reg <= 1'b0;
         if (byte_done) begin
            if (!rx_valid_reg || rx_ready_i) begin
               rx_data_reg  <= rx_byte;
               rx_valid_reg <= 1'b1;
            end else begin
               rx_overrun_reg <= 1'b1;
            end
         end else if (rx_valid_reg && rx_ready_i) begin
            rx_valid_reg <= 1'b0;
         end
      end
   end

   assign miso_o        = miso_reg;
   assign miso_en_o     = !csn_s;
   assign busy_o        = !csn_s;
   assign tx_ready_o    = !hold_full_reg;
   assign rx_data_o     = rx_data_reg;
   assign rx_valid_o    = rx_valid_reg;
   assign tx_underrun_o = tx_underrun_reg;
   assign rx_overrun_o  = rx_overrun_reg;

endmodule

// File: tb/tb_spi_device.sv
// Directed bench for spi_device: one instance per CPOL/CPHA mode, driven by a
// bench-side SPI host task; mode 0 carries the single-mode scenarios.
module tb_spi_device;

   logic       clk;
   logic       rst_n;
   logic [3:0] sck;
   logic [3:0] csn;
   logic [3:0] mosi;
   logic [3:0] miso;
   logic [3:0] miso_en;
   logic [7:0] tx_data [4];
   logic [3:0] tx_valid;
   logic [3:0] tx_ready;
   logic [7:0] rx_data [4];
   logic [3:0] rx_valid;
   logic [3:0] rx_ready;
   logic [3:0] busy;
   logic [3:0] tx_underrun;
   logic [3:0] rx_overrun;

   int tests = 0;
   int fails = 0;
   int urun_cnt [4] = '{0, 0, 0, 0};
   int ovr_cnt  [4] = '{0, 0, 0, 0};
   logic [7:0] rx_log [$];

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      spi_device #(
         .CPOL      (gi >= 2),
         .CPHA      ((gi % 2) == 1),
         .SyncStages(2)
      ) u_dut (
         .clk_i        (clk),
         .rst_ni       (rst_n),
         .sck_i        (sck[gi]),
         .csn_i        (csn[gi]),
         .mosi_i       (mosi[gi]),
         .miso_o       (miso[gi]),
         .miso_en_o    (miso_en[gi]),
         .tx_data_i    (tx_data[gi]),
         .tx_valid_i   (tx_valid[gi]),
         .tx_ready_o   (tx_ready[gi]),
         .rx_data_o    (rx_data[gi]),
         .rx_valid_o   (rx_valid[gi]),
         .rx_ready_i   (rx_ready[gi]),
         .busy_o       (busy[gi]),
         .tx_underrun_o(tx_underrun[gi]),
         .rx_overrun_o (rx_overrun[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (tx_underrun[k]) urun_cnt[k]++;
         if (rx_overrun[k]) ovr_cnt[k]++;
         if (rx_valid[k] && rx_ready[k]) rx_log.push_back(rx_data[k]);
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required to have finished", $time);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic half_period();
      repeat (6) @(negedge clk);
   endtask

   task automatic push_tx(input int m, input logic [7:0] d);
      int t;
      t = 0;
      while (!tx_ready[m] && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check_eq($sformatf("m%0d tx_ready wait", m), 32'(tx_ready[m]), 32'd1);
      tx_data[m]  = d;
      tx_valid[m] = 1'b1;
      @(negedge clk);
      tx_valid[m] = 1'b0;
   endtask

   // Host side of one byte (or nbits of it), LSB first.
   task automatic xfer(input int m, input logic [7:0] d, input int nbits, output logic [7:0] r);
      logic cpol;
      logic cpha;
      cpol = (m >= 2);
      cpha = ((m % 2) == 1);
      r = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            mosi[m] = d[i];
            half_period();
            sck[m] = ~cpol;
            r[i]   = miso[m];
            half_period();
            sck[m] = cpol;
         end else begin
            sck[m]  = ~cpol;
            mosi[m] = d[i];
            half_period();
            sck[m] = cpol;
            r[i]   = miso[m];
            half_period();
         end
      end
      if (!cpha) half_period();
   endtask

   task automatic frame(input int m, input int nbytes, input int nbits,
                        input logic [31:0] hw, output logic [31:0] rw);
      logic [7:0] rb;
      rw = '0;
      csn[m] = 1'b0;
      repeat (8) @(negedge clk);
      check_eq($sformatf("m%0d busy in frame", m), 32'(busy[m]), 32'd1);
      check_eq($sformatf("m%0d miso_en in frame", m), 32'(miso_en[m]), 32'd1);
      for (int b = 0; b < nbytes; b++) begin
         xfer(m, hw[8*b +: 8], nbits, rb);
         rw[8*b +: 8] = rb;
      end
      repeat (8) @(negedge clk);
      csn[m] = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic accept_rx(input int m);
      rx_ready[m] = 1'b1;
      @(negedge clk);
      rx_ready[m] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rw;
      logic [7:0]  h0, h1, t0, t1;
      int base;
      int ubase;
      int obase;
      int t;

      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sck[k]      = (k >= 2);
         csn[k]      = 1'b1;
         mosi[k]     = 1'b0;
         tx_data[k]  = 8'h00;
         tx_valid[k] = 1'b0;
         rx_ready[k] = 1'b0;
      end
      repeat (4) @(negedge clk);

      // Reset state
      check_eq("reset miso", 32'(miso), 32'h0);
      check_eq("reset miso_en", 32'(miso_en), 32'h0);
      check_eq("reset tx_ready", 32'(tx_ready), 32'hF);
      check_eq("reset rx_data", 32'(rx_data[0]), 32'h00);
      check_eq("reset rx_valid", 32'(rx_valid), 32'h0);
      check_eq("reset busy", 32'(busy), 32'h0);
      check_eq("reset tx_underrun", 32'(tx_underrun), 32'h0);
      check_eq("reset rx_overrun", 32'(rx_overrun), 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 1: single byte, tx 0xA5, host sends 0x3C
      push_tx(0, 8'hA5);
      check_eq("t1 tx_ready after load", 32'(tx_ready[0]), 32'd0);
      frame(0, 1, 8, 32'h3C, rw);
      check_eq("t1 host read", rw, 32'hA5);
      check_eq("t1 rx_data", 32'(rx_data[0]), 32'h3C);
      check_eq("t1 rx_valid", 32'(rx_valid[0]), 32'd1);
      check_eq("t1 busy after frame", 32'(busy[0]), 32'd0);
      accept_rx(0);
      check_eq("t1 rx_valid after accept", 32'(rx_valid[0]), 32'd0);

      // 2: back-to-back 0x01, 0x80 with the holding register refilled in time
      rx_ready[0] = 1'b1;
      @(negedge clk);
      base  = rx_log.size();
      ubase = urun_cnt[0];
      obase = ovr_cnt[0];
      push_tx(0, 8'hC3);
      fork
         frame(0, 2, 8, 32'h8001, rw);
         begin
            push_tx(0, 8'h5E);
            push_tx(0, 8'hFF);
         end
      join
      check_eq("t2 host read", rw, 32'h5EC3);
      check_eq("t2 rx count", 32'(rx_log.size() - base), 32'd2);
      if (rx_log.size() >= base + 2) begin
         check_eq("t2 rx byte0", 32'(rx_log[base]), 32'h01);
         check_eq("t2 rx byte1", 32'(rx_log[base+1]), 32'h80);
      end
      check_eq("t2 underruns", 32'(urun_cnt[0] - ubase), 32'd0);
      check_eq("t2 overruns", 32'(ovr_cnt[0] - obase), 32'd0);

      // 3: empty holding register at CSn fall; refilled before the byte completes
      base  = rx_log.size();
      ubase = urun_cnt[0];
      fork
         frame(0, 1, 8, 32'h96, rw);
         begin
            t = 0;
            while (!busy[0] && t < 100) begin
               @(negedge clk);
               t++;
            end
            if (t >= 100) check_eq("t3 busy wait", 32'(busy[0]), 32'd1);
            repeat (10) @(negedge clk);
            push_tx(0, 8'h77);
         end
      join
      check_eq("t3 host read", rw, 32'h00);
      check_eq("t3 underrun pulses", 32'(urun_cnt[0] - ubase), 32'd1);
      check_eq("t3 rx count", 32'(rx_log.size() - base), 32'd1);
      if (rx_log.size() > base) check_eq("t3 rx byte", 32'(rx_log[base]), 32'h96);

      // 4: two bytes with no consumer -> first kept, one overrun
      rx_ready[0] = 1'b0;
      @(negedge clk);
      obase = ovr_cnt[0];
      frame(0, 2, 8, 32'h3412, rw);
      check_eq("t4 rx_data kept", 32'(rx_data[0]), 32'h12);
      check_eq("t4 rx_valid held", 32'(rx_valid[0]), 32'd1);
      check_eq("t4 overrun pulses", 32'(ovr_cnt[0] - obase), 32'd1);
      accept_rx(0);
      check_eq("t4 rx_valid after accept", 32'(rx_valid[0]), 32'd0);

      // 5: CSn raised after 5 bits, then a full 0x5A frame
      rx_ready[0] = 1'b1;
      @(negedge clk);
      base  = rx_log.size();
      obase = ovr_cnt[0];
      push_tx(0, 8'hFF);
      frame(0, 1, 5, 32'hFF, rw);
      check_eq("t5 miso after abort", 32'(miso[0]), 32'd0);
      check_eq("t5 nothing after abort", 32'(rx_log.size() - base), 32'd0);
      frame(0, 1, 8, 32'h5A, rw);
      check_eq("t5 rx count", 32'(rx_log.size() - base), 32'd1);
      if (rx_log.size() > base) check_eq("t5 rx byte", 32'(rx_log[base]), 32'h5A);
      check_eq("t5 overruns", 32'(ovr_cnt[0] - obase), 32'd0);
      rx_ready[0] = 1'b0;

      // 6: all four modes, random two-byte loopback
      for (int m = 0; m < 4; m++) begin
         h0 = 8'($urandom);
         h1 = 8'($urandom);
         t0 = 8'($urandom);
         t1 = 8'($urandom);
         rx_ready[m] = 1'b1;
         @(negedge clk);
         base  = rx_log.size();
         ubase = urun_cnt[m];
         push_tx(m, t0);
         fork
            frame(m, 2, 8, {16'h0, h1, h0}, rw);
            begin
               push_tx(m, t1);
               push_tx(m, 8'hEE);
            end
         join
         check_eq($sformatf("t6 m%0d host read", m), rw, {16'h0, t1, t0});
         check_eq($sformatf("t6 m%0d rx count", m), 32'(rx_log.size() - base), 32'd2);
         if (rx_log.size() >= base + 2) begin
            check_eq($sformatf("t6 m%0d rx byte0", m), 32'(rx_log[base]), 32'(h0));
            check_eq($sformatf("t6 m%0d rx byte1", m), 32'(rx_log[base+1]), 32'(h1));
         end
         check_eq($sformatf("t6 m%0d underruns", m), 32'(urun_cnt[m] - ubase), 32'd0);
         rx_ready[m] = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
